// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM shadow-register block.
//   MODE_*      : encodings of the global update mode input
//   clamp_duty  : limits a duty value to its period, unsigned compare
package pwm_pkg;

  localparam logic [1:0] MODE_PERIOD    = 2'd0;
  localparam logic [1:0] MODE_IMMEDIATE = 2'd1;
  localparam logic [1:0] MODE_HOLD      = 2'd2;

  // Widest value the clamp helper handles; callers zero-extend into it.
  localparam int unsigned MaxWidth = 32;

  function automatic logic [MaxWidth-1:0] clamp_duty(input logic [MaxWidth-1:0] duty,
                                                     input logic [MaxWidth-1:0] freq);
    return (duty > freq) ? freq : duty;
  endfunction

endpackage

// File: rtl/pwm_shadow_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending {freq, duty} pairs for one channel.
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset (flushes pointers)
//   i_wr_en, i_wr_data : push request and data; ignored while full
//   i_rd_en            : pop request; ignored while empty
//   o_rd_data          : head entry, valid whenever o_empty is low
//   o_full, o_empty    : occupancy flags
module pwm_shadow_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the low bits match.
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push, pop;

  assign o_empty   = (wr_ptr_q == rd_ptr_q);
  assign o_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push      = i_wr_en && !o_full;
  assign pop       = i_rd_en && !o_empty;
  assign o_rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/pwm_multich_shadow_regs.sv
// Multi-channel PWM shadow registers. A shared write port queues {freq, duty} pairs per channel;
// entries move into the per-channel active registers according to the global update mode.
// Ports:
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_mode                    : 0 PERIOD, 1 IMMEDIATE, 2/3 HOLD
//   i_wr_en/ch/duty/freq      : shared write port; o_wr_ready = target channel can accept
//   i_period_start            : per-channel period boundary pulse (PERIOD mode pop trigger)
//   i_ovf_clr                 : per-channel clear of the sticky overflow flag
//   o_duty, o_freq            : applied values, channel k at [k*WIDTH +: WIDTH]
//   o_done, o_clamped         : one-cycle pulses on each active-register update
//   o_empty, o_full           : per-channel FIFO state
//   o_overflow                : sticky, set when a write to a full channel is dropped
module pwm_multich_shadow_regs
  import pwm_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned DEPTH    = 8,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [1:0]                i_mode,
  input  logic                      i_wr_en,
  input  logic [CH_W-1:0]           i_wr_ch,
  input  logic [WIDTH-1:0]          i_wr_duty,
  input  logic [WIDTH-1:0]          i_wr_freq,
  output logic                      o_wr_ready,
  input  logic [CHANNELS-1:0]       i_period_start,
  input  logic [CHANNELS-1:0]       i_ovf_clr,
  output logic [CHANNELS*WIDTH-1:0] o_duty,
  output logic [CHANNELS*WIDTH-1:0] o_freq,
  output logic [CHANNELS-1:0]       o_done,
  output logic [CHANNELS-1:0]       o_clamped,
  output logic [CHANNELS-1:0]       o_empty,
  output logic [CHANNELS-1:0]       o_full,
  output logic [CHANNELS-1:0]       o_overflow
);

  logic [CHANNELS-1:0]              wr_sel, pop, ovf_set;
  logic [CHANNELS-1:0]              fifo_full, fifo_empty;
  logic [CHANNELS-1:0][2*WIDTH-1:0] rd_data;

  logic [CHANNELS-1:0][WIDTH-1:0]   duty_q, duty_d, freq_q, freq_d;
  logic [CHANNELS-1:0]              done_q, clamped_q, clamped_d, ovf_q, ovf_d;

  // Write decode: an out-of-range channel selects nothing, so it is silently ignored.
  always_comb begin
    wr_sel = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      wr_sel[k] = (32'(i_wr_ch) < CHANNELS) && (i_wr_ch == CH_W'(k));
    end
  end

  assign o_wr_ready = |(wr_sel & ~fifo_full);
  // The FIFO is sampled before any same-cycle pop, so a pop never rescues a write to a full one.
  assign ovf_set    = {CHANNELS{i_wr_en}} & wr_sel & fifo_full;

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_fifo
    pwm_shadow_fifo #(
      .DW    (2 * WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (i_wr_en && wr_sel[g]),
      .i_wr_data ({i_wr_freq, i_wr_duty}),
      .i_rd_en   (pop[g]),
      .o_rd_data (rd_data[g]),
      .o_full    (fifo_full[g]),
      .o_empty   (fifo_empty[g])
    );
  end

  // Pop decision uses the pre-write empty flag, so a fresh write is never bypassed to the output.
  always_comb begin
    pop = '0;
    case (i_mode)
      MODE_PERIOD:    pop = i_period_start & ~fifo_empty;
      MODE_IMMEDIATE: pop = ~fifo_empty;
      default:        pop = '0;
    endcase
  end

  always_comb begin
    duty_d    = duty_q;
    freq_d    = freq_q;
    clamped_d = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (pop[k]) begin
        freq_d[k]    = rd_data[k][2*WIDTH-1:WIDTH];
        duty_d[k]    = WIDTH'(clamp_duty(MaxWidth'(rd_data[k][WIDTH-1:0]),
                                         MaxWidth'(rd_data[k][2*WIDTH-1:WIDTH])));
        clamped_d[k] = rd_data[k][WIDTH-1:0] > rd_data[k][2*WIDTH-1:WIDTH];
      end
    end
    // Set has priority over clear.
    ovf_d = (ovf_q & ~i_ovf_clr) | ovf_set;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      duty_q    <= '0;
      freq_q    <= '0;
      done_q    <= '0;
      clamped_q <= '0;
      ovf_q     <= '0;
    end else begin
      duty_q    <= duty_d;
      freq_q    <= freq_d;
      done_q    <= pop;
      clamped_q <= clamped_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_duty     = duty_q;
  assign o_freq     = freq_q;
  assign o_done     = done_q;
  assign o_clamped  = clamped_q;
  assign o_overflow = ovf_q;
  assign o_empty    = fifo_empty;
  assign o_full     = fifo_full;

endmodule

// File: tb/tb_pwm_multich_shadow_regs.sv
// Bench for pwm_multich_shadow_regs: directed scenarios plus a randomized run checked against a
// queue-based reference model of the per-channel FIFOs and active registers.
module tb_pwm_multich_shadow_regs;
  import pwm_pkg::*;

  localparam int unsigned W   = 8;
  localparam int unsigned CH  = 4;
  localparam int unsigned D   = 8;
  localparam int unsigned CHW = 2;

  logic            i_clk, i_rst, i_wr_en, o_wr_ready;
  logic [1:0]      i_mode;
  logic [CHW-1:0]  i_wr_ch;
  logic [W-1:0]    i_wr_duty, i_wr_freq;
  logic [CH-1:0]   i_period_start, i_ovf_clr;
  logic [CH*W-1:0] o_duty, o_freq;
  logic [CH-1:0]   o_done, o_clamped, o_empty, o_full, o_overflow;

  pwm_multich_shadow_regs #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .DEPTH    (D)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_mode         (i_mode),
    .i_wr_en        (i_wr_en),
    .i_wr_ch        (i_wr_ch),
    .i_wr_duty      (i_wr_duty),
    .i_wr_freq      (i_wr_freq),
    .o_wr_ready     (o_wr_ready),
    .i_period_start (i_period_start),
    .i_ovf_clr      (i_ovf_clr),
    .o_duty         (o_duty),
    .o_freq         (o_freq),
    .o_done         (o_done),
    .o_clamped      (o_clamped),
    .o_empty        (o_empty),
    .o_full         (o_full),
    .o_overflow     (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel list of pending {freq, duty} pairs and expected outputs.
  logic [2*W-1:0] mq [CH][D];
  int             mcnt [CH];
  logic [W-1:0]   m_duty [CH];
  logic [W-1:0]   m_freq [CH];
  logic [CH-1:0]  m_done, m_clamp, m_ovf;
  logic           obs_ready, mdl_ready;

  // One clock cycle: drive inputs, sample o_wr_ready mid-cycle, advance the model at the edge.
  task automatic step(input logic rst, input logic [1:0] mode, input logic wr,
                      input logic [CHW-1:0] ch, input logic [W-1:0] duty, input logic [W-1:0] freq,
                      input logic [CH-1:0] ps, input logic [CH-1:0] clr);
    int             c;
    logic           wr_ok;
    logic [CH-1:0]  mpop;
    logic [2*W-1:0] e;
    i_rst = rst; i_mode = mode; i_wr_en = wr; i_wr_ch = ch;
    i_wr_duty = duty; i_wr_freq = freq; i_period_start = ps; i_ovf_clr = clr;
    @(negedge i_clk);
    c = int'(ch);
    obs_ready = o_wr_ready;
    mdl_ready = (c < int'(CH)) && (mcnt[c] < int'(D));
    @(posedge i_clk);
    if (rst) begin
      for (int k = 0; k < int'(CH); k++) begin
        mcnt[k] = 0; m_duty[k] = '0; m_freq[k] = '0;
      end
      m_done = '0; m_clamp = '0; m_ovf = '0;
    end else begin
      wr_ok = wr && (c < int'(CH)) && (mcnt[c] < int'(D));
      m_ovf = m_ovf & ~clr;
      if (wr && (c < int'(CH)) && (mcnt[c] == int'(D))) m_ovf[c] = 1'b1;
      for (int k = 0; k < int'(CH); k++) begin
        mpop[k] = (mcnt[k] > 0) && ((mode == MODE_PERIOD) ? ps[k] : (mode == MODE_IMMEDIATE));
      end
      for (int k = 0; k < int'(CH); k++) begin
        m_done[k] = mpop[k];
        m_clamp[k] = 1'b0;
        if (mpop[k]) begin
          e = mq[k][0];
          for (int j = 0; j < int'(D) - 1; j++) mq[k][j] = mq[k][j+1];
          mcnt[k]--;
          m_freq[k]  = e[2*W-1:W];
          m_duty[k]  = (e[W-1:0] > e[2*W-1:W]) ? e[2*W-1:W] : e[W-1:0];
          m_clamp[k] = e[W-1:0] > e[2*W-1:W];
        end
      end
      if (wr_ok) begin
        mq[c][mcnt[c]] = {freq, duty};
        mcnt[c]++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, MODE_PERIOD, 1'b0, '0, '0, '0, '0, '0);
    step(1'b1, MODE_PERIOD, 1'b0, '0, '0, '0, '0, '0);
    checks++; if (o_duty !== '0) begin errors++; $display("FAIL reset_duty: got %h expected 0", o_duty); end
    checks++; if (o_freq !== '0) begin errors++; $display("FAIL reset_freq: got %h expected 0", o_freq); end
    checks++; if (o_done !== '0) begin errors++; $display("FAIL reset_done: got %b expected 0", o_done); end
    checks++; if (o_clamped !== '0) begin errors++; $display("FAIL reset_clamped: got %b expected 0", o_clamped); end
    checks++; if (o_overflow !== '0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", o_overflow); end
    checks++; if (o_empty !== 4'b1111) begin errors++; $display("FAIL reset_empty: got %b expected 1111", o_empty); end
    checks++; if (o_full !== '0) begin errors++; $display("FAIL reset_full: got %b expected 0", o_full); end
  endtask

  task automatic test_period();
    step(1'b0, MODE_PERIOD, 1'b1, 2'd2, 8'd40, 8'd100, '0, '0);
    checks++; if (o_empty[2] !== 1'b0) begin errors++; $display("FAIL period_empty: got %b expected 0", o_empty[2]); end
    checks++; if (o_done !== '0) begin errors++; $display("FAIL period_nobypass: got %b expected 0000", o_done); end
    step(1'b0, MODE_PERIOD, 1'b0, '0, '0, '0, 4'b0100, '0);
    checks++; if (o_duty !== 32'h0028_0000) begin errors++; $display("FAIL period_duty: got %h expected 00280000", o_duty); end
    checks++; if (o_freq !== 32'h0064_0000) begin errors++; $display("FAIL period_freq: got %h expected 00640000", o_freq); end
    checks++; if (o_done !== 4'b0100) begin errors++; $display("FAIL period_done: got %b expected 0100", o_done); end
    step(1'b0, MODE_PERIOD, 1'b0, '0, '0, '0, '0, '0);
    checks++; if (o_done !== '0) begin errors++; $display("FAIL period_done_pulse: got %b expected 0000", o_done); end
    checks++; if (o_duty[23:16] !== 8'd40) begin errors++; $display("FAIL period_hold_val: got %0d expected 40", o_duty[23:16]); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < int'(D); i++) begin
      step(1'b0, MODE_HOLD, 1'b1, 2'd0, W'(i + 1), W'(i + 20), '0, '0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready_%0d: got %b expected 1", i, obs_ready); end
    end
    checks++; if (o_full[0] !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", o_full[0]); end
    step(1'b0, MODE_HOLD, 1'b1, 2'd0, 8'd99, 8'd99, '0, '0);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready_full: got %b expected 0", obs_ready); end
    checks++; if (o_overflow !== 4'b0001) begin errors++; $display("FAIL ovf_set: got %b expected 0001", o_overflow); end
    step(1'b0, MODE_HOLD, 1'b0, '0, '0, '0, '0, 4'b0001);
    checks++; if (o_overflow !== '0) begin errors++; $display("FAIL ovf_clear: got %b expected 0000", o_overflow); end
    step(1'b0, MODE_HOLD, 1'b1, 2'd0, 8'd77, 8'd77, '0, 4'b0001);
    checks++; if (o_overflow !== 4'b0001) begin errors++; $display("FAIL ovf_set_wins: got %b expected 0001", o_overflow); end
    step(1'b0, MODE_HOLD, 1'b0, '0, '0, '0, '0, 4'b0001);
    // Drain: contents must be the original eight entries in order.
    for (int i = 0; i < int'(D); i++) begin
      step(1'b0, MODE_IMMEDIATE, 1'b0, '0, '0, '0, '0, '0);
      checks++; if (o_duty[7:0] !== W'(i + 1)) begin errors++; $display("FAIL ovf_drain_duty_%0d: got %0d expected %0d", i, o_duty[7:0], i + 1); end
      checks++; if (o_freq[7:0] !== W'(i + 20)) begin errors++; $display("FAIL ovf_drain_freq_%0d: got %0d expected %0d", i, o_freq[7:0], i + 20); end
      checks++; if (o_done !== 4'b0001) begin errors++; $display("FAIL ovf_drain_done_%0d: got %b expected 0001", i, o_done); end
    end
    step(1'b0, MODE_IMMEDIATE, 1'b0, '0, '0, '0, '0, '0);
    checks++; if (o_done !== '0) begin errors++; $display("FAIL ovf_drained_done: got %b expected 0000", o_done); end
    checks++; if (o_empty[0] !== 1'b1) begin errors++; $display("FAIL ovf_drained_empty: got %b expected 1", o_empty[0]); end
  endtask

  task automatic test_immediate();
    logic [W-1:0] ed [3];
    logic [W-1:0] ef [3];
    ed[0] = 8'd11; ed[1] = 8'd22; ed[2] = 8'd33;
    ef[0] = 8'd50; ef[1] = 8'd60; ef[2] = 8'd70;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(1'b0, MODE_IMMEDIATE, 1'b1, 2'd1, ed[i], ef[i], '0, '0);
      else       step(1'b0, MODE_IMMEDIATE, 1'b0, '0, '0, '0, '0, '0);
      if (i >= 1 && i <= 3) begin
        checks++; if (o_done !== 4'b0010) begin errors++; $display("FAIL imm_done_%0d: got %b expected 0010", i, o_done); end
        checks++; if (o_duty[15:8] !== ed[i-1]) begin errors++; $display("FAIL imm_duty_%0d: got %0d expected %0d", i, o_duty[15:8], ed[i-1]); end
        checks++; if (o_freq[15:8] !== ef[i-1]) begin errors++; $display("FAIL imm_freq_%0d: got %0d expected %0d", i, o_freq[15:8], ef[i-1]); end
      end else begin
        checks++; if (o_done !== '0) begin errors++; $display("FAIL imm_idle_%0d: got %b expected 0000", i, o_done); end
      end
    end
  endtask

  task automatic test_clamp();
    step(1'b0, MODE_PERIOD, 1'b1, 2'd3, 8'd200, 8'd150, '0, '0);
    step(1'b0, MODE_PERIOD, 1'b0, '0, '0, '0, 4'b1000, '0);
    checks++; if (o_duty[31:24] !== 8'd150) begin errors++; $display("FAIL clamp_duty: got %0d expected 150", o_duty[31:24]); end
    checks++; if (o_freq[31:24] !== 8'd150) begin errors++; $display("FAIL clamp_freq: got %0d expected 150", o_freq[31:24]); end
    checks++; if (o_clamped !== 4'b1000) begin errors++; $display("FAIL clamp_pulse: got %b expected 1000", o_clamped); end
    checks++; if (o_done !== 4'b1000) begin errors++; $display("FAIL clamp_done: got %b expected 1000", o_done); end
    step(1'b0, MODE_PERIOD, 1'b1, 2'd3, 8'd150, 8'd150, '0, '0);
    checks++; if (o_clamped !== '0) begin errors++; $display("FAIL clamp_pulse_len: got %b expected 0000", o_clamped); end
    step(1'b0, MODE_PERIOD, 1'b0, '0, '0, '0, 4'b1000, '0);
    checks++; if (o_clamped !== '0) begin errors++; $display("FAIL clamp_equal: got %b expected 0000", o_clamped); end
    checks++; if (o_done !== 4'b1000) begin errors++; $display("FAIL clamp_equal_done: got %b expected 1000", o_done); end
  endtask

  task automatic test_hold();
    step(1'b0, MODE_HOLD, 1'b1, 2'd2, 8'd55, 8'd90, '0, '0);
    step(1'b0, MODE_HOLD, 1'b1, 2'd2, 8'd66, 8'd90, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, (i == 2) ? 2'd3 : MODE_HOLD, 1'b0, '0, '0, '0, 4'b1111, '0);
      checks++; if (o_done !== '0) begin errors++; $display("FAIL hold_done_%0d: got %b expected 0000", i, o_done); end
      checks++; if (o_duty[23:16] !== 8'd40) begin errors++; $display("FAIL hold_duty_%0d: got %0d expected 40", i, o_duty[23:16]); end
    end
    step(1'b0, MODE_PERIOD, 1'b0, '0, '0, '0, 4'b0100, '0);
    checks++; if (o_duty[23:16] !== 8'd55) begin errors++; $display("FAIL hold_resume_duty: got %0d expected 55", o_duty[23:16]); end
    checks++; if (o_done !== 4'b0100) begin errors++; $display("FAIL hold_resume_done: got %b expected 0100", o_done); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b0, MODE_HOLD, 1'b1, 2'd3, W'(i + 1), 8'd9, '0, '0);
    checks++; if (o_empty[3] !== 1'b0) begin errors++; $display("FAIL midrst_pre_empty: got %b expected 0", o_empty[3]); end
    step(1'b1, MODE_HOLD, 1'b0, '0, '0, '0, '0, '0);
    checks++; if (o_duty !== '0) begin errors++; $display("FAIL midrst_duty: got %h expected 0", o_duty); end
    checks++; if (o_freq !== '0) begin errors++; $display("FAIL midrst_freq: got %h expected 0", o_freq); end
    checks++; if (o_empty !== 4'b1111) begin errors++; $display("FAIL midrst_empty: got %b expected 1111", o_empty); end
    step(1'b0, MODE_PERIOD, 1'b0, '0, '0, '0, 4'b1111, '0);
    checks++; if (o_done !== '0) begin errors++; $display("FAIL midrst_no_done: got %b expected 0000", o_done); end
  endtask

  task automatic test_random();
    logic           rst, wr;
    logic [1:0]     mode;
    logic [CHW-1:0] ch;
    logic [W-1:0]   duty, freq;
    logic [CH-1:0]  ps, clr;
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 99) == 0);
      mode = 2'($urandom_range(0, 3));
      wr   = ($urandom_range(0, 3) != 0);
      ch   = CHW'($urandom_range(0, CH - 1));
      duty = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 12));
      freq = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 12));
      ps   = CH'($urandom_range(0, 15)) & CH'($urandom_range(0, 15));
      clr  = CH'($urandom_range(0, 15)) & CH'($urandom_range(0, 15)) & CH'($urandom_range(0, 15));
      step(rst, mode, wr, ch, duty, freq, ps, clr);
      checks++; if (obs_ready !== mdl_ready) begin errors++; $display("FAIL rnd_ready n=%0d: got %b expected %b", n, obs_ready, mdl_ready); end
      for (int k = 0; k < int'(CH); k++) begin
        checks++; if (o_duty[k*W +: W] !== m_duty[k]) begin errors++; $display("FAIL rnd_duty n=%0d ch%0d: got %0d expected %0d", n, k, o_duty[k*W +: W], m_duty[k]); end
        checks++; if (o_freq[k*W +: W] !== m_freq[k]) begin errors++; $display("FAIL rnd_freq n=%0d ch%0d: got %0d expected %0d", n, k, o_freq[k*W +: W], m_freq[k]); end
        checks++; if (o_done[k] !== m_done[k]) begin errors++; $display("FAIL rnd_done n=%0d ch%0d: got %b expected %b", n, k, o_done[k], m_done[k]); end
        checks++; if (o_clamped[k] !== m_clamp[k]) begin errors++; $display("FAIL rnd_clamped n=%0d ch%0d: got %b expected %b", n, k, o_clamped[k], m_clamp[k]); end
        checks++; if (o_overflow[k] !== m_ovf[k]) begin errors++; $display("FAIL rnd_ovf n=%0d ch%0d: got %b expected %b", n, k, o_overflow[k], m_ovf[k]); end
        checks++; if (o_empty[k] !== (mcnt[k] == 0)) begin errors++; $display("FAIL rnd_empty n=%0d ch%0d: got %b expected count %0d", n, k, o_empty[k], mcnt[k]); end
        checks++; if (o_full[k] !== (mcnt[k] == int'(D))) begin errors++; $display("FAIL rnd_full n=%0d ch%0d: got %b expected count %0d", n, k, o_full[k], mcnt[k]); end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < int'(CH); k++) begin
      mcnt[k] = 0; m_duty[k] = '0; m_freq[k] = '0;
    end
    m_done = '0; m_clamp = '0; m_ovf = '0;
    test_reset();
    test_period();
    test_overflow();
    test_immediate();
    test_clamp();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
